// File: rtl/mem_copy_pkg.sv
// Shared types and default sizing for the mem_copy DMA block.
package mem_copy_pkg;

  localparam int unsigned DefAddrWidth = 32;
  localparam int unsigned DefDataWidth = 32;
  localparam int unsigned DefLenWidth  = 16;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRead  = 2'd1,
    StWrite = 2'd2,
    StDone  = 2'd3
  } state_e;

endpackage

// File: rtl/mem_copy_addrgen.sv
// Word index counter for mem_copy_dma: latches operands, produces src+i / dst+i and the
// last-word flag. Address sums wrap modulo 2^AddrWidth.
module mem_copy_addrgen
  import mem_copy_pkg::*;
#(
  parameter int unsigned AddrWidth = DefAddrWidth,
  parameter int unsigned LenWidth  = DefLenWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 load_i,
  input  logic [AddrWidth-1:0] src_i,
  input  logic [AddrWidth-1:0] dst_i,
  input  logic [LenWidth-1:0]  len_i,
  input  logic                 incr_i,
  output logic [AddrWidth-1:0] src_addr_o,
  output logic [AddrWidth-1:0] dst_addr_o,
  output logic                 last_o
);

  logic [AddrWidth-1:0] src_q, src_d;
  logic [AddrWidth-1:0] dst_q, dst_d;
  logic [LenWidth-1:0]  len_q, len_d;
  logic [LenWidth-1:0]  idx_q, idx_d;
  logic [LenWidth-1:0]  idx_inc;

  assign idx_inc = idx_q + LenWidth'(1);

  always_comb begin
    src_d = src_q;
    dst_d = dst_q;
    len_d = len_q;
    idx_d = idx_q;
    if (load_i) begin
      src_d = src_i;
      dst_d = dst_i;
      len_d = len_i;
      idx_d = '0;
    end else if (incr_i) begin
      idx_d = idx_inc;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      src_q <= '0;
      dst_q <= '0;
      len_q <= '0;
      idx_q <= '0;
    end else begin
      src_q <= src_d;
      dst_q <= dst_d;
      len_q <= len_d;
      idx_q <= idx_d;
    end
  end

  // Compare i+1 rather than i so a full-scale length never needs an extra index bit.
  assign last_o     = (idx_inc == len_q);
  assign src_addr_o = src_q + AddrWidth'(idx_q);
  assign dst_addr_o = dst_q + AddrWidth'(idx_q);

endmodule

// File: rtl/mem_copy_dma.sv
// Word-by-word memory copy engine: READ src+i then WRITE dst+i, ascending, one done pulse.
// Define MEM_COPY_FILL_EN to add fill_mode/fill_value ports for a write-only fill.
module mem_copy_dma
  import mem_copy_pkg::*;
#(
  parameter int unsigned ADDRESSWIDTH = DefAddrWidth,
  parameter int unsigned WIDTH        = DefDataWidth,
  parameter int unsigned LENWIDTH     = DefLenWidth
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDRESSWIDTH-1:0] src_addr,
  input  logic [ADDRESSWIDTH-1:0] dst_addr,
  input  logic [LENWIDTH-1:0]     length,
`ifdef MEM_COPY_FILL_EN
  input  logic                    fill_mode,
  input  logic [WIDTH-1:0]        fill_value,
`endif
  output logic                    busy,
  output logic                    done,
  output logic [ADDRESSWIDTH-1:0] mem_address,
  output logic                    mem_writeEnable,
  output logic [WIDTH-1:0]        mem_dataIn,
  input  logic [WIDTH-1:0]        mem_dataOut
);

  state_e                  state_q, state_d;
  logic [WIDTH-1:0]        buf_q, buf_d;
  logic                    load, incr, last;
  logic [ADDRESSWIDTH-1:0] src_cur, dst_cur;
`ifdef MEM_COPY_FILL_EN
  logic                    fill_q, fill_d;
`endif

  mem_copy_addrgen #(
    .AddrWidth (ADDRESSWIDTH),
    .LenWidth  (LENWIDTH)
  ) u_addrgen (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .load_i     (load),
    .src_i      (src_addr),
    .dst_i      (dst_addr),
    .len_i      (length),
    .incr_i     (incr),
    .src_addr_o (src_cur),
    .dst_addr_o (dst_cur),
    .last_o     (last)
  );

  always_comb begin
    state_d         = state_q;
    buf_d           = buf_q;
    load            = 1'b0;
    incr            = 1'b0;
    busy            = 1'b0;
    done            = 1'b0;
    mem_address     = '0;
    mem_writeEnable = 1'b0;
    mem_dataIn      = '0;
`ifdef MEM_COPY_FILL_EN
    fill_d          = fill_q;
`endif
    case (state_q)
      StIdle: begin
        if (start) begin
          load    = 1'b1;
          state_d = (length != '0) ? StRead : StDone;
`ifdef MEM_COPY_FILL_EN
          fill_d = fill_mode;
          if (fill_mode) begin
            // Fill reuses the copy buffer as the constant source and skips READ.
            buf_d = fill_value;
            if (length != '0) state_d = StWrite;
          end
`endif
        end
      end
      StRead: begin
        busy        = 1'b1;
        mem_address = src_cur;
        buf_d       = mem_dataOut;
        state_d     = StWrite;
      end
      StWrite: begin
        busy            = 1'b1;
        mem_address     = dst_cur;
        mem_writeEnable = 1'b1;
        mem_dataIn      = buf_q;
        incr            = 1'b1;
`ifdef MEM_COPY_FILL_EN
        state_d = last ? StDone : (fill_q ? StWrite : StRead);
`else
        state_d = last ? StDone : StRead;
`endif
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      buf_q   <= '0;
`ifdef MEM_COPY_FILL_EN
      fill_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
`ifdef MEM_COPY_FILL_EN
      fill_q  <= fill_d;
`endif
    end
  end

endmodule

// File: doc/mem_copy_dma.md
MEM_COPY_DMA -- requirements
Module: mem_copy_dma

Interface
REQ-001 Parameter ADDRESSWIDTH, default 32, memory address width in bits.
REQ-002 Parameter WIDTH, default 32, memory data word width in bits.
REQ-003 Parameter LENWIDTH, default 16, transfer length field width in words.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 start  input  1  request pulse; sampled only in IDLE.
REQ-008 src_addr  input  ADDRESSWIDTH  first source word address.
REQ-009 dst_addr  input  ADDRESSWIDTH  first destination word address.
REQ-010 length  input  LENWIDTH  word count; 0 is legal.
REQ-011 busy  output  1  high while a transfer is in progress (READ or WRITE).
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 mem_address  output  ADDRESSWIDTH  memory address.
REQ-014 mem_writeEnable  output  1  memory write strobe, committed on the clk rising edge.
REQ-015 mem_dataIn  output  WIDTH  memory write data.
REQ-016 mem_dataOut  input  WIDTH  memory read data, combinational from mem_address (zero-cycle read).

Function
REQ-017 The FSM SHALL have states IDLE, READ, WRITE and DONE.
REQ-018 Start acceptance SHALL be as follows:
- In IDLE with start=1 at edge E0, the block SHALL latch src_addr, dst_addr and length and clear the word index i.
- If length>0 it SHALL go to READ; otherwise it SHALL go to DONE.
REQ-019 In READ, the block SHALL drive mem_address=src+i with mem_writeEnable=0, capture mem_dataOut into a WIDTH-bit buffer at the edge, and go to WRITE.
REQ-020 In WRITE, the block SHALL drive mem_address=dst+i, mem_writeEnable=1 and mem_dataIn=buffer.
- At the edge, i SHALL increment.
- If i+1==length it SHALL go to DONE; otherwise it SHALL go to READ.
REQ-021 In DONE, done=1 and busy=0 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-022 Latency SHALL be as follows:
- done is high in cycle 2N+1 after E0, for N=length.
- Each word costs exactly 2 cycles.
- length=0 gives done in cycle 1 with no memory access.
REQ-023 Address arithmetic SHALL be modulo 2^ADDRESSWIDTH and wrap silently.
REQ-024 i and the length compare SHALL be LENWIDTH bits wide; length=2^LENWIDTH-1 SHALL complete without overflow.
REQ-025 start while busy or in DONE SHALL be ignored; in-flight latched operands SHALL be unaffected by input changes.
REQ-026 Copy order SHALL be strictly ascending. Overlap with dst in (src, src+length) is not detected, and the resulting data is the defined ascending-order result.
REQ-027 Outside READ/WRITE, mem_writeEnable SHALL be 0 and mem_address and mem_dataIn SHALL be 0.

Reset
REQ-028 rst_n low SHALL asynchronously force IDLE, busy=0, done=0, mem_writeEnable=0, mem_address=0, mem_dataIn=0, i=0 and buffer=0.
REQ-029 Reset mid-transfer SHALL abort with no further write; words already written remain, and no done pulse is produced.

Configuration
REQ-030 With macro MEM_COPY_FILL_EN defined, the block SHALL add the following ports:
- fill_mode  input  1.
- fill_value  input  WIDTH.
REQ-031 Under MEM_COPY_FILL_EN, a start accepted with fill_mode=1 SHALL latch fill_value and skip READ:
- Each WRITE writes fill_value to dst+i.
- Each word costs one cycle, and done is in cycle N+1.
REQ-032 Without MEM_COPY_FILL_EN, the fill ports and fill logic SHALL be absent, and behaviour SHALL be copy-only as above.

Structure
REQ-033 Package mem_copy_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-034 Sub-module mem_copy_addrgen SHALL hold the index counter, src+i/dst+i generation and last-word compare; the FSM stays in mem_copy_dma.

Verification
REQ-035 Copy test: preload mem[0x10..0x13]=A0..A3, start src=0x10 dst=0x40 length=4 -> mem[0x40..0x43]=A0..A3, done in cycle 9 only, busy high in cycles 1-8.
REQ-036 Zero-length test: start with length=0 -> done in cycle 1, mem_writeEnable never asserted.
REQ-037 Wrap test (ADDRESSWIDTH=8): src=0xFE dst=0x20 length=3 -> reads 0xFE,0xFF,0x00 and writes to 0x20..0x22.
REQ-038 Reset test: rst_n low during cycle 4 of a length=4 copy -> writeEnable drops immediately, only word 0 is written, no done, and the next start runs normally.
REQ-039 Ignored-start test: start pulsed while busy with different operands -> the original transfer completes unchanged and no second transfer occurs.
REQ-040 Fill test (MEM_COPY_FILL_EN): fill_mode=1 fill_value=0xDEADBEEF dst=0x80 length=3 -> mem[0x80..0x82]=0xDEADBEEF, done in cycle 4, mem_address never equals src.
